axi_stat_cnt_bank: RTL

Parametrised bank of per-channel event counters for AXI/APB slave status reporting, e.g. read/write transaction counts or error counts per port. Each channel counts single-cycle event pulses. Counters wrap or saturate according to a parameter, and each channel keeps a sticky overflow flag. A register-read port returns one selected channel as a 32-bit word and clears that channel (read-to-clear), with a defined result when an event and a read-clear coincide.

---
 rtl/axi_stat_cnt_bank.sv | 84 ++++++++
 1 files changed

// File: rtl/axi_stat_cnt_bank.sv
// Bank of per-channel event counters with sticky overflow
// and a registered read-to-clear status port.
module axi_stat_cnt_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 10,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ev,
  input  logic [NUM_CH-1:0] cnt_en,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              ovf_any
);

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic             ovf [NUM_CH];
  logic             rd_ok;
  logic [31:0]      rd_word;
  logic             ovf_or;

  assign rd_ok = {1'b0, rd_sel} < (SEL_W+1)'(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    logic inc;
    logic at_max;

    assign hit    = rd_en && rd_ok
                 && (rd_sel == SEL_W'(i));
    assign inc    = ev[i] & cnt_en[i];
    // all-ones compare, not carry-out
    assign at_max = &cnt[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt[i] <= '0;
        ovf[i] <= 1'b0;
      end else if (hit) begin
        // a coincident event survives the clear
        cnt[i] <= CNT_W'(inc);
        ovf[i] <= 1'b0;
      end else if (inc) begin
        if (at_max) begin
          cnt[i] <= (SAT_MODE != 0) ? cnt[i] : '0;
          ovf[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    ovf_or  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      ovf_or = ovf_or | ovf[k];
      if (rd_ok && rd_sel == SEL_W'(k)) begin
        rd_word[31]        = ovf[k];
        rd_word[CNT_W-1:0] = cnt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      ovf_any <= 1'b0;
    end else begin
      rvalid  <= rd_en;
      ovf_any <= ovf_or;
      if (rd_en) begin
        rdata <= rd_word;
      end
    end
  end

endmodule
